hamming_scrubber_32: RTL and testbench
======================================

Name: hamming_scrubber_32

Overview:
- Background scrubber for the TMR register-file storage, which holds 32 entries of 38-bit Hamming codewords produced by the upstream 32-bit encoder.
- On a start pulse it walks all entries and computes each syndrome.
- Single-bit errors are corrected and written back; entries with out-of-range syndromes are flagged.
- Sits directly downstream of the encoder on the storage side and shares the storage port with the core through a hold input.

Parameters:
- DEPTH, 32, number of codeword entries scanned per pass.
- AW, 5, address width (log2 DEPTH).
- CW, 38, codeword width (32 data + 6 parity).
- CNT_W, 8, width of the saturating error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a pass; ignored while busy.
- hold  in  1  core owns the storage port; the scrubber issues no access while high.
- mem_addr  out  AW  storage address.
- mem_rd_en  out  1  read strobe; mem_rdata is valid exactly 1 cycle later.
- mem_rdata  in  CW  read codeword.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  CW  corrected codeword.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- corr_cnt  out  CNT_W  corrected errors this pass, saturating.
- uncorr_cnt  out  CNT_W  uncorrectable entries this pass, saturating.
- err_addr  out  AW  address of the most recent uncorrectable entry.
- err_irq  out  1  sticky; set on any uncorrectable entry; cleared by the next start.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; address pointer 0.
- Bit positions are 1..38 (vector index = position-1). Parity sits at positions 1,2,4,8,16,32 (indices 0,1,3,7,15,31).
- Syndrome bit i = XOR of all codeword bits whose position has bit i set, for i = 0..5 (parity bit included).
- Syndrome 0: entry clean, no write.
- Syndrome 1..38: flip index syndrome-1, write back, corr_cnt++.
- Syndrome 39..63: uncorrectable. No write, uncorr_cnt++, err_addr <= ptr, err_irq <= 1.
- Code is SEC only. Double errors that alias to 1..38 are miscorrected; this is accepted.
- FSM states: IDLE, RD, WAIT, CHK, WR, NEXT, DONE.
- IDLE:
  - On start: clear counters, err_irq and ptr; busy <= 1; go to RD.
- RD:
  - If hold=1, stay with mem_rd_en=0.
  - Otherwise assert mem_rd_en for 1 cycle with mem_addr=ptr, then go to WAIT.
- WAIT:
  - Capture mem_rdata into a register, then go to CHK.
- CHK:
  - Compute the syndrome from the registered word and update the counters.
  - If correctable, go to WR; otherwise go to NEXT.
- WR:
  - If hold=1, stay.
  - Otherwise assert mem_wr_en for 1 cycle with mem_addr=ptr and mem_wdata=corrected word, then go to NEXT.
- NEXT:
  - If ptr=DEPTH-1, go to DONE; otherwise ptr++ and go to RD.
- DONE:
  - done=1 for 1 cycle, busy <= 0, go to IDLE.
- Counters and err_irq hold their values after DONE until the next start.
- Timing: a clean entry takes 4 cycles; a corrected entry takes 5 cycles, plus any hold stall cycles.
- hold asserted in WAIT or CHK does not abort the in-flight read; the captured data is used.
- mem_rd_en and mem_wr_en are never high together and never high while hold=1.
- The counters saturate at 2^CNT_W-1 with no wrap.
- ptr wraps only via restart; no access beyond DEPTH-1.
- rst_n low mid-pass forces IDLE immediately. No partial write is issued after deassertion.
- A start pulse during busy is dropped; a start coincident with done is also dropped.

Test Plan:
- All 32 entries are valid encodings of data 0x00000001 (codeword 38'h0000000007), start -> 32 reads, no writes, done after 128 cycles, corr_cnt=0, uncorr_cnt=0.
- Entry 5 = 38'h0000000003 (index 2 flipped) -> syndrome 3, one write to addr 5 with 38'h0000000007, corr_cnt=1.
- Entry 9 = 38'h0080000040 (indices 31 and 6 flipped from zero word) -> syndrome 39, no write, uncorr_cnt=1, err_addr=9, err_irq=1.
- Hold high for 10 cycles while in RD at entry 3 -> mem_rd_en stays 0 throughout, pass completes 10 cycles later, results unchanged.
- rst_n pulsed low while in WR at entry 12 -> all outputs 0, no mem_wr_en; a new start rescans from addr 0.
- Entries 0..31 each hold a single-bit error, CNT_W=4 -> corr_cnt saturates at 15, 32 writes issued.

Source files
------------

// File: rtl/hamming_scrubber_32.sv
// hamming_scrubber_32: background SEC scrubber that walks a Hamming(38,32) store, corrects single-bit errors in place and flags uncorrectable entries
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   start, hold            pass trigger pulse; core owns the storage port while hold is high
//   mem_addr, mem_rd_en    storage address and read strobe (mem_rdata valid one cycle later)
//   mem_rdata              codeword read back from storage
//   mem_wr_en, mem_wdata   write strobe and corrected codeword
//   busy, done             pass in progress; one-cycle end-of-pass pulse
//   corr_cnt, uncorr_cnt   saturating per-pass counts of corrected and uncorrectable entries
//   err_addr, err_irq      last uncorrectable address; sticky flag cleared by the next start
module hamming_scrubber_32 #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 38,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd_en,
    input  logic [CW-1:0]    mem_rdata,
    output logic             mem_wr_en,
    output logic [CW-1:0]    mem_wdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic [AW-1:0]    err_addr,
    output logic             err_irq
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [5:0]       SYN_MAX = 6'(CW);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0]    PTR_END = AW'(DEPTH - 1);

    logic [2:0]       r_state;
    logic [AW-1:0]    r_ptr;
    logic [CW-1:0]    r_word;
    logic [CW-1:0]    r_fix;
    logic [CNT_W-1:0] r_corr;
    logic [CNT_W-1:0] r_uncorr;
    logic [AW-1:0]    r_err_addr;
    logic             r_err_irq;
    logic [5:0]       w_syn;
    logic [CW-1:0]    w_fixed;
    logic             w_corr;
    logic             w_uncorr;

    // Syndrome bit i covers every position (1-based) with bit i set, parity bits included
    always_comb begin
        w_syn = '0;
        for (int p = 1; p <= CW; p++)
            for (int i = 0; i < 6; i++)
                if (p[i]) w_syn[i] = w_syn[i] ^ r_word[p-1];
    end

    assign w_corr   = (w_syn != 6'd0) && (w_syn <= SYN_MAX);
    assign w_uncorr = w_syn > SYN_MAX;
    assign w_fixed  = r_word ^ (CW'(1) << (w_syn - 6'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_word     <= '0;
            r_fix      <= '0;
            r_corr     <= '0;
            r_uncorr   <= '0;
            r_err_addr <= '0;
            r_err_irq  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_corr    <= '0;
                    r_uncorr  <= '0;
                    r_err_irq <= 1'b0;
                    r_ptr     <= '0;
                    r_state   <= S_RD;
                end
                S_RD: r_state <= hold ? S_RD : S_WAIT;
                // The read was issued last cycle; hold no longer matters for it
                S_WAIT: begin
                    r_word  <= mem_rdata;
                    r_state <= S_CHK;
                end
                S_CHK: begin
                    r_fix <= w_fixed;
                    if (w_corr) r_corr <= (r_corr == CNT_MAX) ? r_corr : r_corr + 1'b1;
                    if (w_uncorr) begin
                        r_uncorr   <= (r_uncorr == CNT_MAX) ? r_uncorr : r_uncorr + 1'b1;
                        r_err_addr <= r_ptr;
                        r_err_irq  <= 1'b1;
                    end
                    r_state <= w_corr ? S_WR : S_NEXT;
                end
                S_WR: r_state <= hold ? S_WR : S_NEXT;
                S_NEXT: begin
                    r_ptr   <= (r_ptr == PTR_END) ? r_ptr : r_ptr + 1'b1;
                    r_state <= (r_ptr == PTR_END) ? S_DONE : S_RD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr   = r_ptr;
    assign mem_rd_en  = (r_state == S_RD) && !hold;
    assign mem_wr_en  = (r_state == S_WR) && !hold;
    assign mem_wdata  = r_fix;
    assign busy       = r_state != S_IDLE;
    assign done       = r_state == S_DONE;
    assign corr_cnt   = r_corr;
    assign uncorr_cnt = r_uncorr;
    assign err_addr   = r_err_addr;
    assign err_irq    = r_err_irq;
endmodule

// File: tb/tb_hamming_scrubber_32.sv
// tb_hamming_scrubber_32: randomized self-checking bench for hamming_scrubber_32 against a pass-level reference model
module tb_hamming_scrubber_32;
    localparam int W = 4;
    localparam int SAT = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [4:0]    mem_addr;
    logic          mem_rd_en;
    logic [37:0]   mem_rdata;
    logic          mem_wr_en;
    logic [37:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  corr_cnt;
    logic [W-1:0]  uncorr_cnt;
    logic [4:0]    err_addr;
    logic          err_irq;

    logic [37:0]   mem [32];
    logic [37:0]   fin [32];
    logic [42:0]   wq [$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            exp_rd, e_corr, e_uncorr, e_eaddr, e_irq, e_cyc;
    int            busy_cyc = 0;
    bit            mon_en = 1'b0;
    bit            got_done = 1'b0;
    bit            ok;

    hamming_scrubber_32 #(.DEPTH(32), .AW(5), .CW(38), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .err_addr(err_addr), .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    // Storage model: one-cycle read latency, write on the strobe edge
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Syndrome = XOR of the 1-based positions of all set bits
    function automatic logic [5:0] syn(input logic [37:0] c);
        int s = 0;
        for (int p = 1; p <= 38; p++) if (c[p-1]) s ^= p;
        return 6'(s);
    endfunction

    function automatic logic [37:0] enc(input logic [31:0] d);
        logic [37:0] c = '0;
        int k = 0;
        logic [5:0] s;
        for (int p = 1; p <= 38; p++)
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        s = syn(c);
        for (int i = 0; i < 6; i++) c[(1 << i) - 1] = s[i];
        return c;
    endfunction

    // Whole-pass expectations from the current storage image
    task automatic plan();
        logic [5:0] s;
        wq.delete();
        exp_rd = 0; e_corr = 0; e_uncorr = 0; e_irq = 0; e_cyc = 0;
        for (int a = 0; a < 32; a++) begin
            s = syn(mem[a]);
            fin[a] = mem[a];
            if (s == 0) e_cyc += 4;
            else if (s <= 38) begin
                fin[a] = mem[a] ^ (38'd1 << (s - 6'd1));
                wq.push_back({5'(a), fin[a]});
                e_corr = (e_corr == SAT) ? SAT : e_corr + 1;
                e_cyc += 5;
            end else begin
                e_uncorr = (e_uncorr == SAT) ? SAT : e_uncorr + 1;
                e_eaddr = a;
                e_irq = 1;
                e_cyc += 4;
            end
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        if (mem_rd_en || mem_wr_en) chk("port_excl", 64'((mem_rd_en & mem_wr_en) | hold), 64'd0);
        if (mem_rd_en) begin
            chk("rd_addr", 64'(mem_addr), 64'(exp_rd));
            exp_rd++;
        end
        if (mem_wr_en) begin
            if (wq.size() == 0) begin
                n_chk++;
                $display("FAIL wr_unexpected: addr %0d data %h, no write was due", mem_addr, mem_wdata);
            end else chk("wr", {21'd0, mem_addr, mem_wdata}, 64'(wq.pop_front()));
        end
        if (busy && !done) busy_cyc++;
        if (done) begin
            chk("corr_cnt", 64'(corr_cnt), 64'(e_corr));
            chk("uncorr_cnt", 64'(uncorr_cnt), 64'(e_uncorr));
            chk("err_irq", 64'(err_irq), 64'(e_irq));
            if (e_irq != 0) chk("err_addr", 64'(err_addr), 64'(e_eaddr));
            chk("reads", 64'(exp_rd), 64'd32);
            chk("writes_left", 64'(wq.size()), 64'd0);
            if (e_cyc >= 0) chk("cycles", 64'(busy_cyc), 64'(e_cyc));
            got_done = 1'b1;
        end
    end

    task automatic run_pass(input string nm);
        int bad = 0;
        busy_cyc = 0;
        got_done = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3000 && !got_done; i++) @(negedge clk);
        if (!got_done) begin
            n_chk++;
            $display("FAIL %s_timeout: no done seen", nm);
        end
        repeat (3) @(negedge clk);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
        chk({nm, "_corr_hold"}, 64'(corr_cnt), 64'(e_corr));
        for (int a = 0; a < 32; a++) if (mem[a] !== fin[a]) bad++;
        chk({nm, "_image"}, 64'(bad), 64'd0);
    endtask

    task automatic wait_rd(input int a, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = mem_rd_en && (mem_addr == 5'(a));
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL wait_rd_%0d: no read seen", a);
        end
    endtask

    task automatic rand_hold();
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk);
            #1 hold = ($urandom_range(3) == 0);
        end
        hold = 1'b0;
    endtask

    task automatic fill_clean();
        for (int a = 0; a < 32; a++) mem[a] = enc(32'h1);
    endtask

    initial begin
        int acc;
        int r;
        int b0;
        int b1;
        #2 rst_n = 1'b0;
        #1 chk("reset_outs", {3'd0, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy, done,
                              corr_cnt, uncorr_cnt, err_addr, err_irq}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("model_enc1", 64'(enc(32'h1)), 64'h7);
        chk("model_syn3", 64'(syn(38'h0000000003)), 64'd3);
        chk("model_syn39", 64'(syn(38'h0080000040)), 64'd39);

        // Clean pass, with a start mid-pass and one coincident with done: both dropped
        fill_clean();
        plan();
        fork
            run_pass("clean");
            begin
                repeat (2) @(posedge clk);
                repeat (40) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                repeat (87) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        chk("clean_cycles", 64'(busy_cyc), 64'd128);

        fill_clean();
        mem[5] = 38'h0000000003;
        plan();
        run_pass("single");
        chk("single_mem5", 64'(mem[5]), 64'h7);
        chk("single_corr", 64'(corr_cnt), 64'd1);

        fill_clean();
        mem[9] = 38'h0080000040;
        plan();
        run_pass("uncorr");
        chk("uncorr_addr", 64'(err_addr), 64'd9);
        chk("uncorr_irq", 64'(err_irq), 64'd1);
        chk("uncorr_cnt9", 64'(uncorr_cnt), 64'd1);

        // Hold covers the 10 RD cycles of entry 3
        fill_clean();
        plan();
        e_cyc += 10;
        got_done = 1'b0;
        fork
            run_pass("hold");
            begin
                wait_rd(2, ok);
                repeat (4) @(posedge clk);
                #1 hold = 1'b1;
                repeat (10) @(posedge clk);
                #1 hold = 1'b0;
            end
        join
        chk("hold_cycles", 64'(busy_cyc), 64'd138);

        // Reset while parked in WR at entry 12
        fill_clean();
        mem[12] = enc(32'h1) ^ 38'h10;
        plan();
        mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_rd(12, ok);
        repeat (3) @(posedge clk);
        #1 hold = 1'b1;
        #2 rst_n = 1'b0;
        mon_en = 1'b0;
        #1 chk("midrst_outs", {3'd0, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy, done,
                               corr_cnt, uncorr_cnt, err_addr, err_irq}, 64'd0);
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_rd_en || mem_wr_en || busy) acc++;
        end
        chk("post_rst_quiet", 64'(acc), 64'd0);
        chk("post_rst_mem12", 64'(mem[12]), 64'(enc(32'h1) ^ 38'h10));
        plan();
        run_pass("rescan");

        // Every entry single-bit: counter saturates
        for (int a = 0; a < 32; a++) mem[a] = enc($urandom) ^ (38'd1 << $urandom_range(37));
        plan();
        run_pass("sat");
        chk("sat_corr", 64'(corr_cnt), 64'(SAT));
        chk("sat_cycles", 64'(busy_cyc), 64'd160);

        // Random images with 0/1/2 flipped bits and random hold
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < 32; a++) begin
                mem[a] = enc($urandom);
                r = $urandom_range(9);
                b0 = $urandom_range(37);
                b1 = (b0 + 1 + $urandom_range(36)) % 38;
                if (r >= 5) mem[a] ^= 38'd1 << b0;
                if (r >= 8) mem[a] ^= 38'd1 << b1;
            end
            plan();
            if (k % 2 == 1) e_cyc = -1;
            got_done = 1'b0;
            if (k % 2 == 1) fork run_pass("rand"); rand_hold(); join
            else run_pass("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
